lsu_mem_stage: RTL and testbench
================================

# lsu_mem_stage

Load/store unit for the single-issue RV32I core, sitting directly downstream of the main control decoder in the memory stage. It consumes the decoder's load/store qualifiers, funct3 and 4-bit byte-write enables together with the ALU-computed address and rs2 data. It runs a req/ack transaction on the data-memory bus and stalls the pipeline while the access is outstanding. It returns aligned, sign- or zero-extended load data to writeback, or flags a misaligned, illegal or timed-out access.

## Interface

Parameters:
- TIMEOUT, 255: maximum cycles mem_req waits for mem_ack before abort; 0 disables the timeout. Counter width is 8 bits.

Ports:
- clk  in  1  core clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid  in  1  the memory-stage instruction is valid.
- mem_read  in  1  the instruction is a load (decoder MemtoReg qualified by the load opcode).
- mem_write  in  1  the instruction is a store.
- funct3  in  3  instruction bits [14:12].
- be  in  4  byte-write enables from the decoder (store only).
- addr  in  32  effective address from the ALU.
- wdata  in  32  rs2 value.
- stall  out  1  holds the upstream pipeline.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle fault pulse, coincident with done.
- ld_data  out  32  extended load result, valid while done=1 and err=0.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write.
- mem_addr  out  32  word-aligned address: addr[31:2] followed by 2'b00.
- mem_wstrb  out  4  bus byte strobes.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  bus completion; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  bus read word.

## Operation

- FSM states are IDLE, BUSY and RESP. Reset forces IDLE and asynchronously drives all outputs and registers to 0, including mem_req.
- start = valid & (mem_read | mem_write), evaluated only in IDLE. If both mem_read and mem_write are set, mem_write wins.
- Fault check at start:
  - halfword access (funct3[1:0]=01) with addr[0]=1 is a fault;
  - word access (funct3[1:0]=10) with addr[1:0]≠00 is a fault;
  - load funct3 in {011,110,111} is a fault;
  - store funct3 other than {000,001,010} is a fault.
- IDLE, start with a fault: go to RESP with err=1 and issue no bus cycle.
- IDLE, start without a fault: latch the access, go to BUSY, clear the timeout counter.
- Registered bus outputs in BUSY:
  - mem_req=1 and mem_we=mem_write.
  - mem_wstrb=be for stores, 4'b0000 for loads.
  - mem_wdata: SB replicates wdata[7:0] to all four lanes; SH replicates wdata[15:0] to both halves; SW passes wdata unchanged.
- BUSY with mem_ack=1: capture the load result, drop mem_req, go to RESP.
- Load extraction: select the byte by addr[1:0] or the halfword by addr[1]. LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word unchanged. Stores report ld_data=0.
- BUSY with no ack: increment the counter. When the counter reaches TIMEOUT (TIMEOUT≠0), drop mem_req and go to RESP with err=1.
- RESP lasts one cycle with done=1, then returns to IDLE. A request is never accepted in RESP.
- The bus stays stable while mem_req=1 until ack; the address, data and strobes must not change.

## Timing

- stall = (IDLE & start) | BUSY, combinational. stall is low in RESP, so writeback captures ld_data on the edge that ends RESP.
- Minimum latency: start in cycle 0, mem_req in cycle 1, ack in cycle 1, done in cycle 2. Three cycles total, with stall high for two.
- A fault at start gives done=err=1 in cycle 1, with stall high only in cycle 0.
- mem_req deasserts in the cycle after ack.
- An ack arriving in IDLE or RESP is ignored.
- Timeout: mem_req stays high for exactly TIMEOUT cycles, then RESP with err=1.
- Asserting rst_n low mid-BUSY aborts the access: mem_req drops immediately and the block returns to IDLE after reset.

## Test plan

- LW at 0x1000, mem_rdata=0xDEADBEEF, ack on the first request cycle -> mem_addr=0x1000, mem_we=0, done in cycle 2, ld_data=0xDEADBEEF, err=0.
- LB at 0x1003 and LBU at 0x1003, rdata=0x80FF_1234 -> ld_data=0xFFFFFF80 and ld_data=0x00000080 respectively.
- SB at 0x2002, be=0100, wdata=0x000000A5, ack delayed 3 cycles -> mem_we=1, mem_wstrb=0100, mem_wdata=0xA5A5A5A5 held stable for 4 cycles; stall high through the ack cycle.
- LH at 0x3001 -> no mem_req; done=err=1 the next cycle. Likewise SW at 0x3002 -> done=err=1, no mem_req.
- TIMEOUT=4, load with no ack -> mem_req high for 4 cycles, then done=err=1, mem_req=0, back to IDLE.
- rst_n pulsed low in the second BUSY cycle -> mem_req=0 and stall=0 asynchronously; the next valid load after release completes normally.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: memory-stage load/store unit for the RV32I core.
// Accepts one access at a time from the decoder, runs a single req/ack
// bus cycle with a bounded wait, stalls the pipeline while it is outstanding,
// and returns extended load data or a fault pulse to writeback.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a valid load/store; stall follows start
// BUSY  | bus request outstanding, bus outputs held stable
// RESP  | one-cycle done pulse (err on fault/timeout), no new accepts
module lsu_mem_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [3:0]  be,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] ld_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] ld_data_q, ld_data_d;

    logic        start;
    logic        is_store;
    logic        is_load;
    logic        fault;
    logic [31:0] rep_wdata;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ld_ext;
    logic [7:0]  cnt_inc;
    logic        timeout_hit;

    assign cnt_inc     = cnt_q + 8'd1;
    assign timeout_hit = (TIMEOUT_C != 8'd0) && (cnt_inc == TIMEOUT_C);

    // Decode the incoming access: start, alignment/funct3 faults, store lane replication.
    always_comb begin
        is_store = mem_write;
        is_load  = mem_read & ~mem_write;
        start    = valid & (mem_read | mem_write);

        fault = 1'b0;
        if ((funct3[1:0] == 2'b01) && addr[0])
            fault = 1'b1;
        if ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00))
            fault = 1'b1;
        if (is_load && ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111)))
            fault = 1'b1;
        if (is_store && !((funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010)))
            fault = 1'b1;

        case (funct3[1:0])
            2'b00:   rep_wdata = {4{wdata[7:0]}};
            2'b01:   rep_wdata = {2{wdata[15:0]}};
            default: rep_wdata = wdata;
        endcase
    end

    // Pick the addressed byte/halfword out of the bus word and extend it.
    always_comb begin
        case (off_q)
            2'b00:   rd_byte = mem_rdata[7:0];
            2'b01:   rd_byte = mem_rdata[15:8];
            2'b10:   rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
        endcase
        rd_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (funct3_q)
            3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  ld_ext = {24'd0, rd_byte};
            3'b101:  ld_ext = {16'd0, rd_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    // Next-state and registered-output logic for the IDLE/BUSY/RESP sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        ld_data_d   = 32'd0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (fault) begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = BUSY;
                        cnt_d       = 8'd0;
                        funct3_d    = funct3;
                        off_d       = addr[1:0];
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_wstrb_d = is_store ? be : 4'b0000;
                        mem_wdata_d = is_store ? rep_wdata : 32'd0;
                    end
                end
            end
            BUSY: begin
                // ack takes priority over a timeout landing in the same cycle
                if (mem_ack || timeout_hit) begin
                    state_d     = RESP;
                    done_d      = 1'b1;
                    err_d       = ~mem_ack;
                    ld_data_d   = (mem_ack && !mem_we_q) ? ld_ext : 32'd0;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = 32'd0;
                    mem_wstrb_d = 4'b0000;
                    mem_wdata_d = 32'd0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything, aborting any bus cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            funct3_q    <= 3'd0;
            off_q       <= 2'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= 32'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ld_data_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ld_data_q   <= ld_data_d;
        end
    end

    // stall is gated by reset so an upstream instruction held during reset cannot assert it.
    assign stall     = rst_n & (((state_q == IDLE) & start) | (state_q == BUSY));
    assign done      = done_q;
    assign err       = err_q;
    assign ld_data   = ld_data_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed vectors for the memory-stage load/store unit.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_lsu_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] ld_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks;
    int failures;

    lsu_mem_stage #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (valid),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .funct3    (funct3),
        .be        (be),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .err       (err),
        .ld_data   (ld_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic drive_idle();
        valid     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        funct3    = 3'd0;
        be        = 4'd0;
        addr      = 32'd0;
        wdata     = 32'd0;
        mem_ack   = 1'b0;
    endtask

    // One full access: start cycle, then either the fault response or the
    // BUSY cycles (ack after ack_dly extra cycles) and the done cycle.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdat, input int ack_dly,
                          input logic exp_err, input logic [31:0] exp_addr,
                          input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_ld);
        @(negedge clk);
        valid     = 1'b1;
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        be        = b;
        addr      = a;
        wdata     = wd;
        mem_rdata = rdat;
        mem_ack   = 1'b0;
        #1;
        chk({tag, "/c0_stall"}, stall, 1);
        chk({tag, "/c0_req"}, mem_req, 0);
        @(negedge clk);
        drive_idle();
        if (exp_err) begin
            #1;
            chk({tag, "/f_done"}, done, 1);
            chk({tag, "/f_err"}, err, 1);
            chk({tag, "/f_req"}, mem_req, 0);
            chk({tag, "/f_stall"}, stall, 0);
        end else begin
            for (int k = 0; k <= ack_dly; k++) begin
                if (k > 0) @(negedge clk);
                mem_ack = (k == ack_dly);
                #1;
                chk({tag, "/b_req"}, mem_req, 1);
                chk({tag, "/b_addr"}, mem_addr, exp_addr);
                chk({tag, "/b_we"}, mem_we, wr);
                chk({tag, "/b_strb"}, mem_wstrb, exp_strb);
                if (wr) chk({tag, "/b_wdata"}, mem_wdata, exp_wdata);
                chk({tag, "/b_stall"}, stall, 1);
                chk({tag, "/b_done"}, done, 0);
            end
            @(negedge clk);
            mem_ack = 1'b0;
            #1;
            chk({tag, "/r_done"}, done, 1);
            chk({tag, "/r_err"}, err, 0);
            chk({tag, "/r_ld"}, ld_data, exp_ld);
            chk({tag, "/r_req"}, mem_req, 0);
            chk({tag, "/r_stall"}, stall, 0);
        end
        @(negedge clk);
        #1;
        chk({tag, "/i_done"}, done, 0);
        chk({tag, "/i_err"}, err, 0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        mem_rdata = 32'd0;
        drive_idle();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_done", done, 0);
        chk("rst_stall", stall, 0);
        chk("rst_ld", ld_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        //      tag        rd    wr    f3      be       addr          wdata         rdata         dly err exp_addr      strb     exp_wdata     exp_ld
        access("lw",       1'b1, 1'b0, 3'b010, 4'b0000, 32'h0000_1000, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 32'h0000_1000, 4'b0000, 32'h0,        32'hDEAD_BEEF);
        access("lb",       1'b1, 1'b0, 3'b000, 4'b0000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 1'b0, 32'h0000_1000, 4'b0000, 32'h0,        32'hFFFF_FF80);
        access("lbu",      1'b1, 1'b0, 3'b100, 4'b0000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 1, 1'b0, 32'h0000_1000, 4'b0000, 32'h0,        32'h0000_0080);
        access("lh",       1'b1, 1'b0, 3'b001, 4'b0000, 32'h0000_1002, 32'h0,        32'h80FF_1234, 0, 1'b0, 32'h0000_1000, 4'b0000, 32'h0,        32'hFFFF_80FF);
        access("lhu",      1'b1, 1'b0, 3'b101, 4'b0000, 32'h0000_1000, 32'h0,        32'h80FF_1234, 0, 1'b0, 32'h0000_1000, 4'b0000, 32'h0,        32'h0000_1234);
        access("sb",       1'b0, 1'b1, 3'b000, 4'b0100, 32'h0000_2002, 32'h0000_00A5, 32'hFFFF_FFFF, 3, 1'b0, 32'h0000_2000, 4'b0100, 32'hA5A5_A5A5, 32'h0);
        access("sh",       1'b0, 1'b1, 3'b001, 4'b1100, 32'h0000_2002, 32'h0000_BEEF, 32'hFFFF_FFFF, 1, 1'b0, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        access("sw",       1'b0, 1'b1, 3'b010, 4'b1111, 32'h0000_2004, 32'h1234_5678, 32'hFFFF_FFFF, 0, 1'b0, 32'h0000_2004, 4'b1111, 32'h1234_5678, 32'h0);
        access("rw_both",  1'b1, 1'b1, 3'b000, 4'b0010, 32'h0000_2001, 32'h0000_005A, 32'hFFFF_FFFF, 0, 1'b0, 32'h0000_2000, 4'b0010, 32'h5A5A_5A5A, 32'h0);
        access("lh_mis",   1'b1, 1'b0, 3'b001, 4'b0000, 32'h0000_3001, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0);
        access("sw_mis",   1'b0, 1'b1, 3'b010, 4'b1111, 32'h0000_3002, 32'h1,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0);
        access("ld_f3_011",1'b1, 1'b0, 3'b011, 4'b0000, 32'h0000_3000, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0);
        access("st_f3_100",1'b0, 1'b1, 3'b100, 4'b0001, 32'h0000_3000, 32'h1,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0);

        // Timeout: no ack, TIMEOUT=4 gives exactly four request cycles.
        @(negedge clk);
        valid    = 1'b1;
        mem_read = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h0000_4000;
        #1;
        chk("to/c0_stall", stall, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive_idle();
            #1;
            chk("to/req", mem_req, 1);
            chk("to/stall", stall, 1);
            chk("to/done", done, 0);
        end
        @(negedge clk);
        #1;
        chk("to/r_done", done, 1);
        chk("to/r_err", err, 1);
        chk("to/r_req", mem_req, 0);
        chk("to/r_stall", stall, 0);
        @(negedge clk);
        #1;
        chk("to/i_done", done, 0);

        // Ack while idle must be ignored.
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("idle_ack/req", mem_req, 0);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("idle_ack/done", done, 0);
        chk("idle_ack/ld", ld_data, 0);

        // Reset in the second BUSY cycle aborts the access immediately.
        @(negedge clk);
        valid    = 1'b1;
        mem_read = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h0000_5004;
        #1;
        chk("rab/c0_stall", stall, 1);
        @(negedge clk);
        #1;
        chk("rab/b1_req", mem_req, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rab/req", mem_req, 0);
        chk("rab/stall", stall, 0);
        chk("rab/addr", mem_addr, 0);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        #1;
        chk("rab/post_req", mem_req, 0);
        access("lw_after_rst", 1'b1, 1'b0, 3'b010, 4'b0000, 32'h0000_5004, 32'h0, 32'h1122_3344, 0, 1'b0, 32'h0000_5004, 4'b0000, 32'h0, 32'h1122_3344);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
